// File: rtl/perf_mon_pkg.sv
// -----------------------------------------------------------------------------
// perf_mon_pkg
//   Shared types and constants for the commit performance monitor.
//   - perf_state_e : monitor FSM state, also exported on o_state and in the
//                    status word.
//   - PERF_RD_*    : read-port address map.
//   - HALT_INSN    : encoding of "jal x0,0", the end-of-program self-loop
//                    that the halt detector looks for. The bench uses it.
// -----------------------------------------------------------------------------
package perf_mon_pkg;

  typedef enum logic [1:0] {
    PS_IDLE   = 2'd0,
    PS_RUN    = 2'd1,
    PS_HALTED = 2'd2
  } perf_state_e;

  localparam logic [2:0] PERF_RD_CYCLES  = 3'd0;
  localparam logic [2:0] PERF_RD_RETIRED = 3'd1;
  localparam logic [2:0] PERF_RD_BUBBLES = 3'd2;
  localparam logic [2:0] PERF_RD_MAXRUN  = 3'd3;
  localparam logic [2:0] PERF_RD_HALTPC  = 3'd4;
  localparam logic [2:0] PERF_RD_STATUS  = 3'd5;

  localparam logic [31:0] HALT_INSN = 32'h0000_006f;

endpackage : perf_mon_pkg

// File: rtl/perf_counter.sv
// -----------------------------------------------------------------------------
// perf_counter
//   Unsigned event counter with synchronous clear.
//   Configuration macro: PERF_SATURATE_EN
//     defined   - the count sticks at all-ones and never wraps
//     undefined - the count wraps modulo 2^W (all-ones + 1 = 0)
// Ports
//   i_clk   in  1  clock
//   i_rstn  in  1  synchronous active-low reset
//   i_clr   in  1  synchronous clear; takes priority over i_inc
//   i_inc   in  1  add one this cycle
//   o_cnt   out W  current count
// -----------------------------------------------------------------------------
module perf_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc) begin
`ifdef PERF_SATURATE_EN
      if (cnt_q != {W{1'b1}}) begin
        cnt_d = cnt_q + W'(1);
      end
`else
      cnt_d = cnt_q + W'(1);
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule : perf_counter

// File: rtl/commit_perf_monitor.sv
// -----------------------------------------------------------------------------
// commit_perf_monitor
//   Watches the core's commit stream and accumulates cycles, retired
//   instructions, bubbles and the longest bubble run. It detects the
//   end-of-program self-loop (the same PC committing HALT_REPEAT times in a
//   row, bubbles in between allowed) and then freezes everything in HALTED
//   until reset or i_clr. All results are visible on a registered read port.
//   Configuration macro: PERF_SATURATE_EN (saturating counters, see
//   perf_counter).
// Ports
//   i_clk       in  1      core clock
//   i_rstn      in  1      synchronous active-low reset
//   i_pc_debug  in  32     PC of the committing instruction
//   i_insn_vld  in  1      1 = instruction committed, 0 = bubble
//   i_clr       in  1      synchronous soft clear of all state
//   i_rd_addr   in  3      read select (PERF_RD_*; 6 and 7 read 0)
//   o_rd_data   out CNT_W  selected value, one cycle after i_rd_addr
//   o_halted    out 1      halt detected (sticky)
//   o_state     out 2      FSM state
// Parameters
//   CNT_W        counter width, >= 32 so the halt PC fits on the read bus
//   HALT_REPEAT  consecutive same-PC commits that declare halt, >= 2
// -----------------------------------------------------------------------------
module commit_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [31:0]      i_pc_debug,
  input  logic             i_insn_vld,
  input  logic             i_clr,
  input  logic [2:0]       i_rd_addr,
  output logic [CNT_W-1:0] o_rd_data,
  output logic             o_halted,
  output perf_state_e      o_state
);

  localparam int RPT_W = $clog2(HALT_REPEAT);

  perf_state_e      state_q,    state_d;
  logic [CNT_W-1:0] max_run_q,  max_run_d;
  logic [31:0]      halt_pc_q,  halt_pc_d;
  logic [31:0]      last_pc_q,  last_pc_d;
  logic [RPT_W-1:0] rpt_q,      rpt_d;
  logic [CNT_W-1:0] rd_data_q,  rd_data_d;

  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] bubbles;
  logic [CNT_W-1:0] cur_run;

  logic cyc_inc;
  logic ret_inc;
  logic bub_inc;
  logic run_inc;
  logic run_clr;

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  perf_counter #(.W(CNT_W)) u_cycles (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (i_clr),
    .i_inc (cyc_inc),
    .o_cnt (cycles)
  );

  perf_counter #(.W(CNT_W)) u_retired (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (i_clr),
    .i_inc (ret_inc),
    .o_cnt (retired)
  );

  perf_counter #(.W(CNT_W)) u_bubbles (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (i_clr),
    .i_inc (bub_inc),
    .o_cnt (bubbles)
  );

  // The current bubble run restarts at every commit, so its clear also fires
  // on a counted commit, not only on the soft clear.
  perf_counter #(.W(CNT_W)) u_cur_run (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_clr (run_clr),
    .i_inc (run_inc),
    .o_cnt (cur_run)
  );

  // ---------------------------------------------------------------------------
  // FSM next state, counter enables, halt detection and max_run
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    max_run_d = max_run_q;
    halt_pc_d = halt_pc_q;
    last_pc_d = last_pc_q;
    rpt_d     = rpt_q;
    cyc_inc   = 1'b0;
    ret_inc   = 1'b0;
    bub_inc   = 1'b0;
    run_inc   = 1'b0;
    run_clr   = i_clr;

    if (i_clr) begin
      // A commit in the clear cycle is dropped on purpose.
      state_d   = PS_IDLE;
      max_run_d = '0;
      halt_pc_d = '0;
      last_pc_d = '0;
      rpt_d     = '0;
    end else begin
      unique case (state_q)
        PS_IDLE: begin
          // Pre-fill bubbles are ignored; the first commit starts the run
          // and is itself counted.
          if (i_insn_vld) begin
            state_d   = PS_RUN;
            cyc_inc   = 1'b1;
            ret_inc   = 1'b1;
            last_pc_d = i_pc_debug;
            rpt_d     = '0;
          end
        end

        PS_RUN: begin
          cyc_inc = 1'b1;
          if (i_insn_vld) begin
            ret_inc   = 1'b1;
            run_clr   = 1'b1;
            last_pc_d = i_pc_debug;
            if (cur_run > max_run_q) begin
              max_run_d = cur_run;
            end
            // Bubbles leave rpt_q alone; only a commit at a new PC resets it.
            if (i_pc_debug == last_pc_q) begin
              rpt_d = rpt_q + RPT_W'(1);
            end else begin
              rpt_d = '0;
            end
            if (rpt_d == RPT_W'(HALT_REPEAT - 1)) begin
              state_d   = PS_HALTED;
              halt_pc_d = i_pc_debug;
            end
          end else begin
            bub_inc = 1'b1;
            run_inc = 1'b1;
          end
        end

        PS_HALTED: begin
          // Everything frozen until reset or i_clr.
        end

        default: begin
          state_d = PS_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_d = '0;
    if (!i_clr) begin
      unique case (i_rd_addr)
        PERF_RD_CYCLES:  rd_data_d = cycles;
        PERF_RD_RETIRED: rd_data_d = retired;
        PERF_RD_BUBBLES: rd_data_d = bubbles;
        PERF_RD_MAXRUN:  rd_data_d = max_run_q;
        PERF_RD_HALTPC:  rd_data_d = CNT_W'(halt_pc_q);
        PERF_RD_STATUS:  rd_data_d = CNT_W'({o_halted, state_q});
        default:         rd_data_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= PS_IDLE;
      max_run_q <= '0;
      halt_pc_q <= '0;
      last_pc_q <= '0;
      rpt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      max_run_q <= max_run_d;
      halt_pc_q <= halt_pc_d;
      last_pc_q <= last_pc_d;
      rpt_q     <= rpt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_halted  = (state_q == PS_HALTED);
  assign o_state   = state_q;
  assign o_rd_data = rd_data_q;

endmodule : commit_perf_monitor

// File: tb/tb_commit_perf_monitor.sv
// -----------------------------------------------------------------------------
// tb_commit_perf_monitor
//   Directed bench for commit_perf_monitor. Each read request pushes its
//   hand-computed expected value into a scoreboard queue; a monitor process
//   pops and compares one cycle later, when o_rd_data carries the answer.
//   A read cycle drives i_insn_vld=0, so in RUN every read is itself a bubble;
//   the expected values below account for that.
// -----------------------------------------------------------------------------
module tb_commit_perf_monitor;
  import perf_mon_pkg::*;

  typedef struct {
    logic [31:0] exp;
    string       nm;
  } sb_t;

`ifdef PERF_SATURATE_EN
  localparam logic [31:0] EXP_RET_EDGE = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_RET_EDGE = 32'h0000_0001;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc;
  logic        vld;
  logic        clr;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        halted;
  logic [1:0]  state;
  bit          rd_req;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  commit_perf_monitor #(.CNT_W(32), .HALT_REPEAT(4)) u_dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_pc_debug(pc),
    .i_insn_vld(vld),
    .i_clr     (clr),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_halted  (halted),
    .o_state   (state)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive at a falling edge, return at the next one.
  task automatic drive(input logic v, input logic [31:0] p, input logic [2:0] a,
                       input bit r, input logic [31:0] e, input string nm);
    vld     = v;
    pc      = p;
    rd_addr = a;
    rd_req  = r;
    if (r) sb_q.push_back('{e, nm});
    @(negedge clk);
  endtask

  task automatic commit(input logic [31:0] p);
    drive(1'b1, p, 3'd0, 1'b0, 32'h0, "");
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, "");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    drive(1'b0, 32'h0, a, 1'b1, e, nm);
  endtask

  task automatic soft_clear();
    clr = 1'b1;
    bubble();
    clr = 1'b0;
  endtask

  // Monitor: a read issued before edge N is answered after edge N.
  initial begin : monitor
    sb_t e;
    forever begin
      @(posedge clk);
      if (rd_req) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: read with no expected value (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check(e.nm, rd_data, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rstn = 1'b0; clr = 1'b0; vld = 1'b0; pc = '0; rd_addr = '0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_halted",  32'(halted), 32'h0);
    check("rst_state",   32'(state), 32'(PS_IDLE));
    rstn = 1'b1;
    rd(PERF_RD_STATUS, 32'h0, "idle_status");

    // 1) five back-to-back commits
    commit(32'h00); commit(32'h04); commit(32'h08); commit(32'h0C); commit(32'h10);
    check("t1_state", 32'(state), 32'(PS_RUN));
    rd(PERF_RD_CYCLES,  32'd5, "t1_cycles");   // c5 r5 b0 before this edge
    rd(PERF_RD_RETIRED, 32'd5, "t1_retired");
    rd(PERF_RD_BUBBLES, 32'd2, "t1_bubbles");  // the two previous reads
    rd(PERF_RD_STATUS,  32'd1, "t1_status");
    rd(PERF_RD_CYCLES,  32'd9, "t1_cycles_inv"); // 5 retired + 4 bubbles
    rd(PERF_RD_MAXRUN,  32'd0, "t1_maxrun");

    // 2) vld 1,0,0,0,1,0,1 after a clear and two ignored pre-fill bubbles
    soft_clear();
    bubble(); bubble();
    commit(32'h100); bubble(); bubble(); bubble();
    commit(32'h104); bubble();
    commit(32'h108);
    rd(PERF_RD_BUBBLES, 32'd4,  "t2_bubbles");
    rd(PERF_RD_RETIRED, 32'd3,  "t2_retired");
    rd(PERF_RD_MAXRUN,  32'd3,  "t2_maxrun");   // max_run moves only at a commit
    rd(PERF_RD_CYCLES,  32'd10, "t2_cycles");   // 7 + three read bubbles

    // 3) halt on PC 0x40 committed four times, bubble between first two
    soft_clear();
    commit(32'h30);
    commit(32'h40); bubble(); commit(32'h40); commit(32'h40);
    check("t3_pre_halted", 32'(halted), 32'h0);
    check("t3_pre_state",  32'(state), 32'(PS_RUN));
    commit(32'h40);
    check("t3_halted", 32'(halted), 32'h1);
    check("t3_state",  32'(state), 32'(PS_HALTED));
    for (int i = 0; i < 20; i++) begin
      drive(logic'(i[0]), 32'h80 + 32'(i) * 4, 3'd0, 1'b0, 32'h0, "");
    end
    // 6) address sweep 0..7 while frozen: c6 r5 b1 max1 pc0x40 status 6
    rd(3'd0, 32'd6,  "t3_cycles");
    rd(3'd1, 32'd5,  "t3_retired");
    rd(3'd2, 32'd1,  "t3_bubbles");
    rd(3'd3, 32'd1,  "t3_maxrun");
    rd(3'd4, 32'h40, "t3_haltpc");
    rd(3'd5, 32'd6,  "t3_status");
    rd(3'd6, 32'd0,  "t3_addr6");
    rd(3'd7, 32'd0,  "t3_addr7");

    // 4) clear coinciding with a commit while in RUN
    soft_clear();
    check("t4_clr_from_halt", 32'(state), 32'(PS_IDLE));
    commit(32'h200); commit(32'h204);
    clr = 1'b1;
    commit(32'h208);
    clr = 1'b0;
    check("t4_state",  32'(state), 32'(PS_IDLE));
    check("t4_halted", 32'(halted), 32'h0);
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), 32'h0, $sformatf("t4_zero_%0d", a));
    end
    commit(32'h300);
    rd(PERF_RD_RETIRED, 32'd1, "t4_restart_retired");
    rd(PERF_RD_CYCLES,  32'd2, "t4_restart_cycles");

    // 5) retired counter at the wrap/saturation boundary
    force u_dut.u_retired.cnt_q = 32'hFFFF_FFFE;
    #1;
    release u_dut.u_retired.cnt_q;
    commit(32'h400); commit(32'h404); commit(32'h408);
    rd(PERF_RD_RETIRED, EXP_RET_EDGE, "t5_retired_edge");

    // 7) one-cycle reset mid-RUN with a live read select and a commit
    rstn = 1'b0;
    drive(1'b1, 32'h500, PERF_RD_RETIRED, 1'b0, 32'h0, "");
    check("t7_rd_data", rd_data, 32'h0);
    check("t7_halted",  32'(halted), 32'h0);
    check("t7_state",   32'(state), 32'(PS_IDLE));
    rstn = 1'b1;
    rd(PERF_RD_RETIRED, 32'h0, "t7_retired");
    rd(PERF_RD_CYCLES,  32'h0, "t7_cycles");

    bubble(); bubble();
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_commit_perf_monitor
